// File: rtl/sd_spi_byte_master.sv
// SPI mode-0 byte master for SD-card access: shifts one byte out on MOSI and one in from MISO.
// Define SD_SPI_CS_CTRL_EN to have the block drive spi_cs_n_p itself; otherwise it is tied high.
module sd_spi_byte_master #(
    parameter int CLK_DIV_HALF = 4
) (
    input  logic       clk_p,
    input  logic       rst_p,
    input  logic       init_transfer_p,
    input  logic [7:0] data_to_transfer_p,
    input  logic       spi_miso_p,
    output logic       spi_sck_p,
    output logic       spi_mosi_p,
    output logic       spi_cs_n_p,
    output logic [7:0] spi_data_in_p,
    output logic       transfer_done_p,
    output logic       busy_p
);

    typedef enum logic [1:0] {
        IDLE,
        SCK_LOW,
        SCK_HIGH,
        DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV_HALF - 1);

    state_t     state_q,   state_d;
    logic [7:0] div_q,     div_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] tx_q,      tx_d;
    logic [7:0] rx_q,      rx_d;
    logic [7:0] data_in_q, data_in_d;
    logic       sck_q,     sck_d;
    logic       mosi_q,    mosi_d;
    logic       done_q,    done_d;
    logic       div_end;

    assign div_end = (div_q == DIV_LAST);

    // Bit 7 goes straight onto MOSI at the start edge, so only the remaining seven bits are kept.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_in_d = data_in_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        done_d    = done_q;

        unique case (state_q)
            IDLE: begin
                sck_d  = 1'b0;
                mosi_d = 1'b1;
                done_d = 1'b0;
                if (init_transfer_p) begin
                    tx_d      = data_to_transfer_p[6:0];
                    mosi_d    = data_to_transfer_p[7];
                    bit_cnt_d = 3'd0;
                    div_d     = 8'd0;
                    rx_d      = 8'd0;
                    data_in_d = 8'd0;
                    state_d   = SCK_LOW;
                end
            end

            SCK_LOW: begin
                if (div_end) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[6:0], spi_miso_p};
                    div_d   = 8'd0;
                    state_d = SCK_HIGH;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            SCK_HIGH: begin
                if (div_end) begin
                    sck_d = 1'b0;
                    div_d = 8'd0;
                    if (bit_cnt_q != 3'd7) begin
                        mosi_d    = tx_q[6];
                        tx_d      = {tx_q[5:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = SCK_LOW;
                    end else begin
                        mosi_d    = 1'b1;
                        done_d    = 1'b1;
                        data_in_d = rx_q;
                        state_d   = DONE;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            DONE: begin
                if (!init_transfer_p) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 7'd0;
            rx_q      <= 8'd0;
            data_in_q <= 8'd0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_in_q <= data_in_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

`ifdef SD_SPI_CS_CTRL_EN
    logic cs_n_q, cs_n_d;

    // Chip select frames exactly the shifting phase: low from the start edge until DONE is entered.
    always_comb begin
        cs_n_d = cs_n_q;
        if (state_q == IDLE && init_transfer_p) begin
            cs_n_d = 1'b0;
        end else if (state_q == SCK_HIGH && div_end && bit_cnt_q == 3'd7) begin
            cs_n_d = 1'b1;
        end
    end

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            cs_n_q <= 1'b1;
        end else begin
            cs_n_q <= cs_n_d;
        end
    end

    assign spi_cs_n_p = cs_n_q;
`else
    assign spi_cs_n_p = 1'b1;
`endif

    assign spi_sck_p       = sck_q;
    assign spi_mosi_p      = mosi_q;
    assign spi_data_in_p   = data_in_q;
    assign transfer_done_p = done_q;
    assign busy_p          = (state_q != IDLE);

endmodule

// File: tb/tb_sd_spi_byte_master.sv
// Scoreboard bench for sd_spi_byte_master: instance 0 runs with CLK_DIV_HALF=4, instance 1 with 7.
// An SD-card slave model (or MOSI->MISO loopback) answers each byte; a monitor checks every done.
`timescale 1ns/1ps
module tb_sd_spi_byte_master;

    typedef struct {
        int         inst;
        logic [7:0] dout;
        logic [7:0] slave;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] init;
    logic [7:0] din [2];
    logic [1:0] miso;
    logic [1:0] sck, mosi, cs_n, done, busy;
    logic [7:0] dout [2];

    logic       loop_mode;
    logic [7:0] slave_byte;
    logic [7:0] slave_tx [2];
    logic [7:0] slave_rx [2];
    int         rise_cnt [2];

    exp_t exp_q [$];

    int vectors       = 0;
    int miscompares   = 0;
    int timeouts      = 0;
    int chk_reset_req = 0;
    bit chk_final_req = 1'b0;
    bit final_ack     = 1'b0;

    always #5 clk = ~clk;

    assign miso[0] = loop_mode ? mosi[0] : slave_tx[0][7];
    assign miso[1] = loop_mode ? mosi[1] : slave_tx[1][7];

    sd_spi_byte_master #(.CLK_DIV_HALF(4)) dut4 (
        .clk_p              (clk),
        .rst_p              (rst),
        .init_transfer_p    (init[0]),
        .data_to_transfer_p (din[0]),
        .spi_miso_p         (miso[0]),
        .spi_sck_p          (sck[0]),
        .spi_mosi_p         (mosi[0]),
        .spi_cs_n_p         (cs_n[0]),
        .spi_data_in_p      (dout[0]),
        .transfer_done_p    (done[0]),
        .busy_p             (busy[0])
    );

    sd_spi_byte_master #(.CLK_DIV_HALF(7)) dut7 (
        .clk_p              (clk),
        .rst_p              (rst),
        .init_transfer_p    (init[1]),
        .data_to_transfer_p (din[1]),
        .spi_miso_p         (miso[1]),
        .spi_sck_p          (sck[1]),
        .spi_mosi_p         (mosi[1]),
        .spi_cs_n_p         (cs_n[1]),
        .spi_data_in_p      (dout[1]),
        .transfer_done_p    (done[1]),
        .busy_p             (busy[1])
    );

    function automatic int divOf(input int g);
        return (g == 0) ? 4 : 7;
    endfunction

    // Only the monitor calls this, so it is the sole writer of the counters.
    task automatic checkOutput(input string name, input int g, input logic [31:0] act,
                               input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s (inst %0d): got 0x%0h, expected 0x%0h", name, g, act, exp);
        end
    endtask

    task automatic waitDone(input int g);
        int n = 0;
        while (!done[g] && n < 16 * divOf(g) + 40) begin
            @(posedge clk); #2;
            n++;
        end
        if (!done[g]) begin
            timeouts++;
            $display("[TB] timeout waiting for done on inst %0d", g);
        end
    endtask

    task automatic releaseInit(input int g, input int hold);
        int n = 0;
        repeat (hold) begin
            @(posedge clk); #2;
        end
        init[g] = 1'b0;
        while (done[g] && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        @(posedge clk); #2;
    endtask

    // Queue the expectation, start the byte, then scramble din to prove it was latched.
    task automatic applyStimulus(input int g, input logic [7:0] tx, input logic [7:0] rx_exp,
                                 input int hold);
        exp_t e;
        e.inst  = g;
        e.dout  = rx_exp;
        e.slave = tx;
        e.lat   = 16 * divOf(g);
        exp_q.push_back(e);
        @(posedge clk); #2;
        din[g]  = tx;
        init[g] = 1'b1;
        @(posedge clk); #2;
        din[g]  = ~tx;
        waitDone(g);
        releaseInit(g, hold);
    endtask

    initial begin : stimulus
        exp_t e;
        int   n;
        init       = 2'b00;
        din[0]     = 8'h00;
        din[1]     = 8'h00;
        loop_mode  = 1'b0;
        slave_byte = 8'hA5;
        repeat (4) @(posedge clk);
        #2;
        chk_reset_req++;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        $display("[TB] slave model returns 0xA5, send 0x3C, hold request 200 cycles");
        applyStimulus(0, 8'h3C, 8'hA5, 200);

        $display("[TB] loopback bytes");
        loop_mode = 1'b1;
        applyStimulus(0, 8'h00, 8'h00, 2);
        applyStimulus(0, 8'hFF, 8'hFF, 0);
        applyStimulus(0, 8'h81, 8'h81, 1);
        applyStimulus(0, 8'h96, 8'h96, 3);

        $display("[TB] reset after third SCK rise");
        @(posedge clk); #2;
        din[0]  = 8'h55;
        init[0] = 1'b1;
        @(negedge clk); #1;
        n = 0;
        while (rise_cnt[0] < 3 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (rise_cnt[0] < 3) timeouts++;
        rst = 1'b1;
        @(posedge clk); #2;
        chk_reset_req++;
        din[0]  = 8'h47;
        e.inst  = 0;
        e.dout  = 8'h47;
        e.slave = 8'h47;
        e.lat   = 64;
        exp_q.push_back(e);
        rst = 1'b0;
        waitDone(0);
        releaseInit(0, 2);

        $display("[TB] CLK_DIV_HALF=7 instance, slave returns 0xC3, send 0x5A");
        loop_mode  = 1'b0;
        slave_byte = 8'hC3;
        applyStimulus(1, 8'h5A, 8'hC3, 3);

        repeat (5) @(posedge clk);
        #2;
        chk_final_req = 1'b1;
        n = 0;
        while (!final_ack && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        if (!final_ack) begin
            $display("[TB] FAIL final_check: monitor never acknowledged");
            $fatal(1, "[TB] monitor stalled");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Samples everything on the falling clock edge, away from the DUT's active edge.
    initial begin : monitor
        logic [1:0] sck_prev, mosi_prev, done_prev, busy_prev, init_prev;
        logic [7:0] dout_prev [2];
        logic       rst_prev;
        bit         armed;
        int         cyc, start_cyc [2], last_rise [2], exp_w;
        int         mosi_err, width_err, idle_err, hold_err, cs_err, chk_reset_seen;
        exp_t       e;
        sck_prev = '0; mosi_prev = '0; done_prev = '0; busy_prev = '0; init_prev = '0;
        dout_prev[0] = '0; dout_prev[1] = '0;
        rst_prev = 1'b0; armed = 1'b0; cyc = 0;
        mosi_err = 0; width_err = 0; idle_err = 0; hold_err = 0; cs_err = 0; chk_reset_seen = 0;
        for (int g = 0; g < 2; g++) begin
            start_cyc[g] = 0; last_rise[g] = 0; rise_cnt[g] = 0;
            slave_tx[g] = 8'h00; slave_rx[g] = 8'h00;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_prev) armed = 1'b1;
            if (chk_reset_req != chk_reset_seen) begin
                chk_reset_seen = chk_reset_req;
                for (int g = 0; g < 2; g++) begin
                    checkOutput("reset_sck", g, 32'(sck[g]), 32'd0);
                    checkOutput("reset_mosi", g, 32'(mosi[g]), 32'd1);
                    checkOutput("reset_cs_n", g, 32'(cs_n[g]), 32'd1);
                    checkOutput("reset_done", g, 32'(done[g]), 32'd0);
                    checkOutput("reset_busy", g, 32'(busy[g]), 32'd0);
                    checkOutput("reset_data_in", g, 32'(dout[g]), 32'd0);
                end
            end
            for (int g = 0; g < 2; g++) begin
                if (!busy[g]) slave_tx[g] = slave_byte;
                if (armed) begin
                    if (busy[g] && !busy_prev[g]) begin
                        start_cyc[g] = cyc;
                        last_rise[g] = cyc;
                        rise_cnt[g]  = 0;
                        slave_rx[g]  = 8'h00;
                    end
                    if (sck[g] && !sck_prev[g]) begin
                        exp_w = (rise_cnt[g] == 0) ? divOf(g) : 2 * divOf(g);
                        if (cyc - last_rise[g] != exp_w) width_err++;
                        last_rise[g] = cyc;
                        rise_cnt[g]++;
                        slave_rx[g] = {slave_rx[g][6:0], mosi[g]};
                    end
                    if (!sck[g] && sck_prev[g] && !rst_prev) begin
                        if (cyc - last_rise[g] != divOf(g)) width_err++;
                        slave_tx[g] = {slave_tx[g][6:0], 1'b0};
                    end
                    if (mosi[g] != mosi_prev[g] &&
                        !(!sck[g] && (sck_prev[g] || (busy[g] && !busy_prev[g]) || rst_prev)))
                        mosi_err++;
                    if (!busy[g] && (sck[g] || !mosi[g] || done[g])) idle_err++;
                    if (done_prev[g] && !rst_prev) begin
                        if (done[g] != init_prev[g]) hold_err++;
                        if (done[g] && dout[g] != dout_prev[g]) hold_err++;
                    end
`ifdef SD_SPI_CS_CTRL_EN
                    if (cs_n[g] != !(busy[g] && !done[g])) cs_err++;
`else
                    if (cs_n[g] != 1'b1) cs_err++;
`endif
                    if (done[g] && !done_prev[g]) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("done_unexpected", g, 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            checkOutput("done_instance", g, 32'(g), 32'(e.inst));
                            checkOutput("data_in", g, 32'(dout[g]), 32'(e.dout));
                            checkOutput("done_latency", g, 32'(cyc - start_cyc[g]), 32'(e.lat));
                            checkOutput("sck_rises", g, 32'(rise_cnt[g]), 32'd8);
                            checkOutput("slave_rx", g, 32'(slave_rx[g]), 32'(e.slave));
                        end
                    end
                end
                sck_prev[g]  = sck[g];
                mosi_prev[g] = mosi[g];
                done_prev[g] = done[g];
                busy_prev[g] = busy[g];
                init_prev[g] = init[g];
                dout_prev[g] = dout[g];
            end
            rst_prev = rst;
            if (chk_final_req && !final_ack) begin
                checkOutput("mosi_edge_errors", 0, 32'(mosi_err), 32'd0);
                checkOutput("sck_width_errors", 0, 32'(width_err), 32'd0);
                checkOutput("idle_level_errors", 0, 32'(idle_err), 32'd0);
                checkOutput("done_hold_errors", 0, 32'(hold_err), 32'd0);
                checkOutput("cs_n_errors", 0, 32'(cs_err), 32'd0);
                checkOutput("wait_timeouts", 0, 32'(timeouts), 32'd0);
                checkOutput("pending_expected", 0, 32'(exp_q.size()), 32'd0);
                final_ack = 1'b1;
            end
        end
    end

endmodule

// File: doc/sd_spi_byte_master.md
SD_SPI_BYTE_MASTER -- requirements
Module: sd_spi_byte_master

Interface
REQ-001 Parameter CLK_DIV_HALF, default 4, meaning clk_p cycles per SCK half-period; legal range is 4..255.
REQ-002 clk_p  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_p  input  1  reset, synchronous, active-high.
REQ-004 init_transfer_p  input  1  transfer request, level-held by the requester until done is seen.
REQ-005 data_to_transfer_p  input  8  byte to shift out MSB-first, sampled only when a transfer starts.
REQ-006 spi_miso_p  input  1  serial data from the card.
REQ-007 spi_sck_p  output  1  SPI clock, mode 0 (idle low).
REQ-008 spi_mosi_p  output  1  serial data to the card, idle high.
REQ-009 spi_cs_n_p  output  1  active-low chip select.
REQ-010 spi_data_in_p  output  8  byte received MSB-first.
REQ-011 transfer_done_p  output  1  transfer-complete flag.
REQ-012 busy_p  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SCK_LOW, SCK_HIGH, DONE.
REQ-014 IDLE: sck=0, mosi=1, done=0.
REQ-015 IDLE->SCK_LOW on the edge sampling init_transfer_p=1, which SHALL also latch the tx byte, drive mosi=bit7, and clear bit counter, divider, rx shift register and spi_data_in_p.
REQ-016 SCK_LOW: the divider SHALL count 0..CLK_DIV_HALF-1; at terminal count it SHALL set sck=1, shift spi_miso_p into the rx register LSB, clear the divider and go to SCK_HIGH.
REQ-017 SCK_HIGH: at terminal count it SHALL set sck=0 and clear the divider.
REQ-018 SCK_HIGH, if bit counter<7: it SHALL drive the next tx bit on mosi, increment the counter and go to SCK_LOW.
REQ-019 SCK_HIGH, if bit counter=7: it SHALL set mosi=1, transfer_done_p=1, load spi_data_in_p with the rx register and go to DONE.
REQ-020 Latency: transfer_done_p SHALL rise exactly 16*CLK_DIV_HALF clk_p edges after the edge that sampled init_transfer_p=1; exactly 8 SCK rising edges SHALL occur per byte.
REQ-021 MOSI SHALL change only on the edge that drives sck low, or on the start edge, never while sck=1.
REQ-022 DONE: done, mosi=1 and spi_data_in_p SHALL be held until init_transfer_p=0 is sampled, then done=0 and the FSM SHALL return to IDLE in that cycle.
REQ-023 Back-to-back transfers: a new byte SHALL start only from IDLE, so a minimum of one IDLE cycle separates transfers.
REQ-024 init_transfer_p deasserting mid-transfer SHALL be ignored; the byte SHALL complete.
REQ-025 Changes on data_to_transfer_p after the start edge SHALL NOT affect the byte in flight.

Reset
REQ-026 rst_p=1 SHALL, on the next edge, force IDLE with sck=0, mosi=1, cs_n=1, done=0, busy=0, spi_data_in_p=0, and all counters zero.
REQ-027 Reset mid-transfer SHALL abort the transfer with no done pulse; init_transfer_p high after reset release SHALL start a fresh transfer.

Configuration
REQ-028 Macro SD_SPI_CS_CTRL_EN: when defined, spi_cs_n_p SHALL go 0 on the start edge and return to 1 on the edge entering DONE.
REQ-029 Without SD_SPI_CS_CTRL_EN, spi_cs_n_p SHALL be constant 1 (chip select owned externally); all other behaviour SHALL be identical.

Verification
REQ-030 With CLK_DIV_HALF=4 and an SD card slave model returning 0xA5, sending 0x3C SHALL give model rx=0x3C, spi_data_in_p=0xA5, and done 64 cycles after start.
REQ-031 With MOSI looped to MISO, sending 0x00, 0xFF and 0x81 in turn SHALL return the same bytes, with 8 SCK pulses each and SCK low between bytes.
REQ-032 Holding init_transfer_p high for 200 cycles SHALL keep done=1 and spi_data_in_p stable; dropping it SHALL clear done on the next edge.
REQ-033 Asserting rst_p after the 3rd SCK rise SHALL give sck=0, mosi=1, busy=0 next cycle, and no done.
REQ-034 With SD_SPI_CS_CTRL_EN defined, cs_n SHALL be low exactly from the start edge to DONE entry; with it undefined, cs_n SHALL stay 1 throughout.
REQ-035 With CLK_DIV_HALF=7 and 0x5A sent, SCK high and low widths SHALL each be 7 cycles and done SHALL come 112 cycles after start.
